// File: rtl/mw_writeback_pkg.sv
// Shared decode definitions for the writeback (W) stage of the 5-stage MIPS pipeline.
// This package holds:
//   - the opcode and funct constants;
//   - the write-data and write-address select encodings;
//   - the load-type encoding;
//   - a decode helper that maps an instruction to its writeback controls.
// The hazard unit's Tnew/Tuse decode imports the same constants.
package mw_writeback_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  // Source of the register-file write data
  typedef enum logic [1:0] {WD_AO, WD_DM, WD_PC8} wd_sel_t;

  // Source of the register-file write address; A3_NONE marks a non-writing instruction
  typedef enum logic [1:0] {A3_NONE, A3_RD, A3_RT, A3_RA} a3_sel_t;

  // Width/signedness of a load
  typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_type_t;

  typedef struct packed {
    a3_sel_t  a3_sel;
    wd_sel_t  wd_sel;
    ld_type_t ld_type;
  } wb_ctrl_t;

  function automatic wb_ctrl_t wb_decode(input logic [5:0] op, input logic [5:0] funct);
    wb_ctrl_t c;
    c.a3_sel  = A3_NONE;
    c.wd_sel  = WD_AO;
    c.ld_type = LD_W;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_SLT, FN_SLL: c.a3_sel = A3_RD;
          FN_JALR: begin
            c.a3_sel = A3_RD;
            c.wd_sel = WD_PC8;
          end
          default: c.a3_sel = A3_NONE;  // jr and anything unsupported
        endcase
      end
      OP_ADDIU, OP_ORI, OP_LUI: c.a3_sel = A3_RT;
      OP_LW:  begin c.a3_sel = A3_RT; c.wd_sel = WD_DM; c.ld_type = LD_W;  end
      OP_LB:  begin c.a3_sel = A3_RT; c.wd_sel = WD_DM; c.ld_type = LD_B;  end
      OP_LBU: begin c.a3_sel = A3_RT; c.wd_sel = WD_DM; c.ld_type = LD_BU; end
      OP_LH:  begin c.a3_sel = A3_RT; c.wd_sel = WD_DM; c.ld_type = LD_H;  end
      OP_LHU: begin c.a3_sel = A3_RT; c.wd_sel = WD_DM; c.ld_type = LD_HU; end
      OP_JAL: begin c.a3_sel = A3_RA; c.wd_sel = WD_PC8; end
      default: c.a3_sel = A3_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mw_writeback_load_ext.sv
// Load extension for the W stage (purely combinational).
// Ports:
//   dr      - raw aligned word read from data memory
//   ao_lo   - low two address bits (byte lane select, little-endian)
//   ld_type - load width/signedness
//   ext     - extended 32-bit load result
module mw_writeback_load_ext
  import mw_writeback_pkg::*;
(
  input  logic [31:0] dr,
  input  logic [1:0]  ao_lo,
  input  ld_type_t    ld_type,
  output logic [31:0] ext
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = dr[7:0];
    case (ao_lo)
      2'd1:    byte_val = dr[15:8];
      2'd2:    byte_val = dr[23:16];
      2'd3:    byte_val = dr[31:24];
      default: byte_val = dr[7:0];
    endcase
    // Bit 0 never selects anything for halfwords; misaligned halfwords are trapped upstream
    half_val = ao_lo[1] ? dr[31:16] : dr[15:0];

    ext = dr;
    case (ld_type)
      LD_B:    ext = {{24{byte_val[7]}}, byte_val};
      LD_BU:   ext = {24'h0, byte_val};
      LD_H:    ext = {{16{half_val[15]}}, half_val};
      LD_HU:   ext = {16'h0, half_val};
      default: ext = dr;
    endcase
  end

endmodule

// File: rtl/mw_writeback.sv
// W stage of the 5-stage MIPS CPU: the M/W pipeline register plus the writeback logic.
// Ports:
//   Clk, Reset                 - clock and synchronous active-high reset
//   IRM, PC8M, AOM, DRM        - instruction, PC+8, ALU result and memory word from M
//   IRW, PC8W                  - registered instruction/PC+8, used as the forwarding source
//   MUX_RF_A3_OUT, MUX_RF_WD_OUT, We - register-file write port (driven from W registers only)
//   Retired                    - count of non-bubble instructions latched into W
module mw_writeback
  import mw_writeback_pkg::*;
#(
  parameter int RETIRE_W   = 32,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [31:0]         IRM,
  input  logic [31:0]         PC8M,
  input  logic [31:0]         AOM,
  input  logic [31:0]         DRM,
  output logic [31:0]         IRW,
  output logic [31:0]         PC8W,
  output logic [4:0]          MUX_RF_A3_OUT,
  output logic [31:0]         MUX_RF_WD_OUT,
  output logic                We,
  output logic [RETIRE_W-1:0] Retired
);

  logic [31:0]         ir_reg;
  logic [31:0]         pc8_reg;
  logic [31:0]         ao_reg;
  logic [31:0]         dr_reg;
  logic [RETIRE_W-1:0] retired_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // Clearing IR turns the W slot into a bubble (sll $0), so the discarded
      // instruction never writes the register file.
      ir_reg      <= '0;
      pc8_reg     <= '0;
      ao_reg      <= '0;
      dr_reg      <= '0;
      retired_reg <= '0;
    end else begin
      ir_reg  <= IRM;
      pc8_reg <= PC8M;
      ao_reg  <= AOM;
      dr_reg  <= DRM;
      if (IRM != 32'h0) begin
        retired_reg <= retired_reg + RETIRE_W'(1);
      end
    end
  end

  wb_ctrl_t    ctrl;
  logic [4:0]  a3;
  logic [31:0] wd_raw;
  logic [31:0] load_data;

  mw_writeback_load_ext load_ext (
    .dr      (dr_reg),
    .ao_lo   (ao_reg[1:0]),
    .ld_type (ctrl.ld_type),
    .ext     (load_data)
  );

  always_comb begin
    ctrl = wb_decode(ir_reg[31:26], ir_reg[5:0]);

    case (ctrl.a3_sel)
      A3_RD:   a3 = ir_reg[15:11];
      A3_RT:   a3 = ir_reg[20:16];
      A3_RA:   a3 = 5'd31;
      default: a3 = 5'd0;
    endcase

    case (ctrl.wd_sel)
      WD_PC8:  wd_raw = pc8_reg;
      WD_DM:   wd_raw = load_data;
      default: wd_raw = ao_reg;
    endcase
  end

  assign IRW           = ir_reg;
  assign PC8W          = pc8_reg;
  assign Retired       = retired_reg;
  assign MUX_RF_A3_OUT = a3;
  // Non-writing instructions (and writes aimed at $0) present zero data
  assign MUX_RF_WD_OUT = (a3 == 5'd0) ? 32'h0 : wd_raw;
  assign We            = (ctrl.a3_sel != A3_NONE) && !(ZERO_GUARD && (a3 == 5'd0));

endmodule

// File: tb/tb_mw_writeback.sv
module tb_mw_writeback;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] IRM, PC8M, AOM, DRM;

  logic [31:0] irw0, pc8w0, wd0, retired0;
  logic [4:0]  a30;
  logic        we0;

  logic [31:0] irw1, pc8w1, wd1;
  logic [4:0]  a31;
  logic        we1;
  logic [3:0]  retired1;

  int checks = 0;
  int passed = 0;

  always #5 Clk = ~Clk;

  // Default configuration
  mw_writeback #(.RETIRE_W(32), .ZERO_GUARD(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .IRM(IRM), .PC8M(PC8M), .AOM(AOM), .DRM(DRM),
    .IRW(irw0), .PC8W(pc8w0), .MUX_RF_A3_OUT(a30), .MUX_RF_WD_OUT(wd0),
    .We(we0), .Retired(retired0)
  );

  // Narrow counter, no $0 guard
  mw_writeback #(.RETIRE_W(4), .ZERO_GUARD(1'b0)) dut_ng (
    .Clk(Clk), .Reset(Reset), .IRM(IRM), .PC8M(PC8M), .AOM(AOM), .DRM(DRM),
    .IRW(irw1), .PC8W(pc8w1), .MUX_RF_A3_OUT(a31), .MUX_RF_WD_OUT(wd1),
    .We(we1), .Retired(retired1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Drive one set of M inputs, clock it into W, then sample away from the edge
  task automatic step(input logic [31:0] ir, input logic [31:0] pc8,
                      input logic [31:0] ao, input logic [31:0] dr);
    IRM = ir; PC8M = pc8; AOM = ao; DRM = dr;
    @(posedge Clk);
    #1;
  endtask

  task automatic wb(input string tag, input logic [4:0] a3, input logic [31:0] wd,
                    input logic we, input logic [31:0] ret);
    chk({tag, ".a3"}, {27'h0, a30}, {27'h0, a3});
    chk({tag, ".wd"}, wd0, wd);
    chk({tag, ".we"}, {31'h0, we0}, {31'h0, we});
    chk({tag, ".ret"}, retired0, ret);
    $display("step %-10s IRW=%h A3=%0d WD=%h We=%0d Retired=%0d",
             tag, irw0, a30, wd0, we0, retired0);
  endtask

  initial begin
    Reset = 1'b1;
    step($urandom, $urandom, $urandom, $urandom);
    step($urandom, $urandom, $urandom, $urandom);
    chk("rst.irw", irw0, 32'h0);
    chk("rst.pc8w", pc8w0, 32'h0);
    chk("rst.ret_ng", {28'h0, retired1}, 32'h0);
    wb("reset", 5'd0, 32'h0, 1'b0, 32'd0);

    Reset = 1'b0;
    step(32'h0022_1821, 32'h0, 32'h0000_0005, 32'h0);           // addu $3,$1,$2
    wb("addu", 5'd3, 32'h5, 1'b1, 32'd1);

    step(32'h80A4_0000, 32'h0, 32'h0000_1002, 32'h8899_AABB);    // lb
    wb("lb", 5'd4, 32'hFFFF_FF99, 1'b1, 32'd2);
    step(32'h90A4_0000, 32'h0, 32'h0000_1002, 32'h8899_AABB);    // lbu
    wb("lbu", 5'd4, 32'h0000_0099, 1'b1, 32'd3);
    step(32'h84A4_0000, 32'h0, 32'h0000_1000, 32'h8899_AABB);    // lh
    wb("lh", 5'd4, 32'hFFFF_AABB, 1'b1, 32'd4);
    step(32'h94A4_0000, 32'h0, 32'h0000_1002, 32'h8899_AABB);    // lhu
    wb("lhu", 5'd4, 32'h0000_8899, 1'b1, 32'd5);
    step(32'h8CA4_0000, 32'h0, 32'h0000_1003, 32'h8899_AABB);    // lw, low bits ignored
    wb("lw", 5'd4, 32'h8899_AABB, 1'b1, 32'd6);
    step(32'h84A4_0000, 32'h0, 32'h0000_1001, 32'h8899_AABB);    // lh, bit 0 ignored
    wb("lh_b0", 5'd4, 32'hFFFF_AABB, 1'b1, 32'd7);

    step(32'h0C00_0C03, 32'h0000_300C, 32'h0000_1234, 32'h0);    // jal
    wb("jal", 5'd31, 32'h0000_300C, 1'b1, 32'd8);
    chk("jal.pc8w", pc8w0, 32'h0000_300C);
    step(32'h0040_F809, 32'h0000_4008, 32'h0000_1234, 32'h0);    // jalr $31,$2
    wb("jalr", 5'd31, 32'h0000_4008, 1'b1, 32'd9);

    step(32'hAC22_0004, 32'h0, 32'h0000_1234, 32'h0);            // sw
    wb("sw", 5'd0, 32'h0, 1'b0, 32'd10);
    step(32'h1022_0003, 32'h0, 32'h0000_1234, 32'h0);            // beq
    wb("beq", 5'd0, 32'h0, 1'b0, 32'd11);
    step(32'h03E0_0008, 32'h0, 32'h0000_1234, 32'h0);            // jr $31
    wb("jr", 5'd0, 32'h0, 1'b0, 32'd12);

    step(32'h2400_0001, 32'h0, 32'h0000_0001, 32'h0);            // addiu $0,$0,1
    wb("addiu0", 5'd0, 32'h0, 1'b0, 32'd13);
    chk("addiu0.we_ng", {31'h0, we1}, 32'd1);
    chk("addiu0.a3_ng", {27'h0, a31}, 32'd0);
    chk("addiu0.ret_ng", {28'h0, retired1}, 32'd13);

    step(32'h3427_00FF, 32'h0, 32'h0000_00FF, 32'h0);            // ori $7,$1,0xff
    wb("ori", 5'd7, 32'h0000_00FF, 1'b1, 32'd14);
    step(32'h3C08_1234, 32'h0, 32'h1234_0000, 32'h0);            // lui $8,0x1234
    wb("lui", 5'd8, 32'h1234_0000, 1'b1, 32'd15);
    chk("pre_wrap.ret_ng", {28'h0, retired1}, 32'd15);
    step(32'h0022_4823, 32'h0, 32'h0000_0007, 32'h0);            // subu $9
    wb("subu", 5'd9, 32'h0000_0007, 1'b1, 32'd16);
    chk("wrap.ret_ng", {28'h0, retired1}, 32'd0);
    step(32'h0022_502A, 32'h0, 32'h0000_0001, 32'h0);            // slt $10
    wb("slt", 5'd10, 32'h0000_0001, 1'b1, 32'd17);
    chk("post_wrap.ret_ng", {28'h0, retired1}, 32'd1);

    // Counter with interleaved bubbles
    Reset = 1'b1;
    step(32'h0022_1821, 32'h0, 32'h0, 32'h0);
    chk("rst2.ret", retired0, 32'd0);
    Reset = 1'b0;
    step(32'h0022_1821, 32'h0, 32'h0000_0005, 32'h0);
    wb("addu_b", 5'd3, 32'h5, 1'b1, 32'd1);
    step(32'h0, 32'h0, 32'h0000_0077, 32'h0);
    wb("bubble1", 5'd0, 32'h0, 1'b0, 32'd1);
    chk("bubble1.irw", irw0, 32'h0);
    step(32'h3427_00FF, 32'h0, 32'h0000_00FF, 32'h0);
    wb("ori_b", 5'd7, 32'h0000_00FF, 1'b1, 32'd2);
    step(32'h0, 32'h0, 32'h0, 32'h0);
    wb("bubble2", 5'd0, 32'h0, 1'b0, 32'd2);
    step(32'h8CA4_0000, 32'h0, 32'h0000_1000, 32'h8899_AABB);
    wb("lw_b", 5'd4, 32'h8899_AABB, 1'b1, 32'd3);

    // Reset while lw is in W: no write, counter cleared
    Reset = 1'b1;
    step(32'h0022_1821, 32'h0, 32'h0000_0005, 32'h0);
    wb("rst_mid", 5'd0, 32'h0, 1'b0, 32'd0);
    chk("rst_mid.irw", irw0, 32'h0);
    Reset = 1'b0;
    step(32'h0, 32'h0, 32'h0, 32'h0);
    wb("after_rst", 5'd0, 32'h0, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
